uart_rx_parity: RTL and testbench

- UART receiver with parity check; the downstream partner of the team's parity-enabled uart_tx.
- Recovers start, DBIT data bits (LSB first), one parity bit and stop bit(s) from the serial line, oversampled by the shared 16x baud-tick generator (s_tick).
- Presents the received byte with a one-cycle done strobe plus parity and framing error flags to the consuming FIFO/interface logic.

---
 rtl/uart_rx_parity_if.sv | 19 +
 rtl/uart_rx_parity.sv | 135 +++++++++++++
 tb/tb_uart_rx_parity.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_parity_if.sv
// Serial-line and received-frame signals between a UART line/tick source and the parity receiver.
interface uart_rx_parity_if;
  logic       rx;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output rx, s_tick,
    input  dout, rx_done_tick, parity_err, frame_err
  );

  modport slave (
    input  rx, s_tick,
    output dout, rx_done_tick, parity_err, frame_err
  );
endinterface

// File: rtl/uart_rx_parity.sv
// UART receiver with parity check, 16x oversampled; 2-clk rx sync, result strobed SB_TICK-1 ticks into the stop bit.
// No backpressure: dout and the error flags hold until the next completed frame, so the consumer samples on rx_done_tick.
module uart_rx_parity #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter bit PAR_ODD = 1'b0
) (
  input  logic clk,
  input  logic reset,
  uart_rx_parity_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [4:0] S_MID  = 5'd7;
  localparam logic [4:0] S_BIT  = 5'd15;
  localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST = 3'(DBIT - 1);

  state_t            state;
  logic [4:0]        s_reg;
  logic [2:0]        n_reg;
  logic [DBIT-1:0]   b_reg;
  logic [DBIT-1:0]   b_next;
  logic [7:0]        b_ext;
  logic              acc;
  logic              perr;
  logic              rx_q;
  logic              rx_s;

  // Right shift with the new bit entering at the MSB, so LSB-first data lands right-aligned.
  always_comb begin
    b_next         = b_reg >> 1;
    b_next[DBIT-1] = rx_s;
  end

  always_comb begin
    b_ext           = '0;
    b_ext[DBIT-1:0] = b_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q             <= 1'b1;
      rx_s             <= 1'b1;
      state            <= IDLE;
      s_reg            <= '0;
      n_reg            <= '0;
      b_reg            <= '0;
      acc              <= 1'b0;
      perr             <= 1'b0;
      bus.dout         <= '0;
      bus.rx_done_tick <= 1'b0;
      bus.parity_err   <= 1'b0;
      bus.frame_err    <= 1'b0;
    end else begin
      rx_q             <= bus.rx;
      rx_s             <= rx_q;
      bus.rx_done_tick <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_reg <= '0;
            acc   <= 1'b0;
          end
        end

        START: begin
          if (bus.s_tick) begin
            if (s_reg == S_MID) begin
              s_reg <= '0;
              // A line that is high again at mid start bit was a glitch.
              if (!rx_s) begin
                state <= DATA;
                n_reg <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end

        DATA: begin
          if (bus.s_tick) begin
            if (s_reg == S_BIT) begin
              b_reg <= b_next;
              acc   <= acc ^ rx_s;
              s_reg <= '0;
              if (n_reg == N_LAST) begin
                state <= PARITY;
              end else begin
                n_reg <= n_reg + 3'd1;
              end
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end

        PARITY: begin
          if (bus.s_tick) begin
            if (s_reg == S_BIT) begin
              perr  <= rx_s ^ acc ^ PAR_ODD;
              s_reg <= '0;
              state <= STOP;
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end

        STOP: begin
          if (bus.s_tick) begin
            if (s_reg == S_STOP) begin
              bus.dout         <= b_ext;
              bus.parity_err   <= perr;
              bus.frame_err    <= ~rx_s;
              bus.rx_done_tick <= 1'b1;
              state            <= IDLE;
            end else begin
              s_reg <= s_reg + 5'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed-frame bench for uart_rx_parity: an even- and an odd-parity receiver share one line,
// a frame-level model predicts every strobe and the held outputs in between.
module tb_uart_rx_parity;

  localparam int BIT_CLK = 64;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       stop;
  } frame_t;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic rx     = 1'b1;
  logic s_tick = 1'b0;

  int checks = 0;
  int errors = 0;

  frame_t     frames[$];
  int         rd[2];
  int         stb_cnt[2];
  logic [9:0] held[2];

  uart_rx_parity_if if_e ();
  uart_rx_parity_if if_o ();

  assign if_e.rx     = rx;
  assign if_e.s_tick = s_tick;
  assign if_o.rx     = rx;
  assign if_o.s_tick = s_tick;

  uart_rx_parity #(.DBIT(8), .SB_TICK(16), .PAR_ODD(1'b0)) dut_e (
    .clk   (clk),
    .reset (reset),
    .bus   (if_e)
  );

  uart_rx_parity #(.DBIT(8), .SB_TICK(16), .PAR_ODD(1'b1)) dut_o (
    .clk   (clk),
    .reset (reset),
    .bus   (if_o)
  );

  always #5 clk = ~clk;

  // One s_tick pulse every 4 clk.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      s_tick = (ph == 0);
      ph = (ph + 1) % 4;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {parity_err, frame_err, dout} for a frame as the receiver should judge it.
  function automatic logic [9:0] expect_of(frame_t f, bit odd);
    logic pe;
    pe = (^f.data) ^ f.par ^ odd;
    return {pe, ~f.stop, f.data};
  endfunction

  // Compare process: every cycle, a strobe must match the next expected frame, otherwise outputs hold.
  initial begin
    logic [9:0] obs[2];
    logic       stb[2];
    logic [9:0] exp;
    for (int k = 0; k < 2; k++) begin
      rd[k]      = 0;
      stb_cnt[k] = 0;
      held[k]    = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      obs[0] = {if_e.parity_err, if_e.frame_err, if_e.dout};
      stb[0] = if_e.rx_done_tick;
      obs[1] = {if_o.parity_err, if_o.frame_err, if_o.dout};
      stb[1] = if_o.rx_done_tick;
      for (int k = 0; k < 2; k++) begin
        if (stb[k] === 1'b1) begin
          stb_cnt[k]++;
          if (rd[k] < frames.size()) begin
            exp     = expect_of(frames[rd[k]], k == 1);
            rd[k]   = rd[k] + 1;
            held[k] = exp;
            chk($sformatf("frame_dut%0d", k), {22'd0, obs[k]}, {22'd0, exp});
          end else begin
            chk($sformatf("spurious_strobe_dut%0d", k), 32'd1, 32'd0);
          end
        end else begin
          chk($sformatf("hold_dut%0d", k), {22'd0, obs[k]}, {22'd0, held[k]});
        end
      end
    end
  end

  task automatic drive_bit(logic v, int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe_seen();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("strobe_seen_dut%0d", k), rd[k], frames.size());
      rd[k] = frames.size();
    end
  endtask

  task automatic send(logic [7:0] d, logic par, logic stop);
    frame_t f;
    f.data = d;
    f.par  = par;
    f.stop = stop;
    frames.push_back(f);
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLK);
    drive_bit(par, BIT_CLK);
    if (stop) begin
      drive_bit(1'b1, BIT_CLK);
    end else begin
      // Low through the sample point, then high early so the re-armed receiver sees a false start.
      drive_bit(1'b0, 48);
      drive_bit(1'b1, 16);
    end
    strobe_seen();
  endtask

  initial begin
    int s0;
    int s1;
    #1_500_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int s1;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dout", {24'd0, if_e.dout}, 32'h0);
    chk("reset_flags", {30'd0, if_e.parity_err, if_e.frame_err}, 32'h0);
    chk("reset_strobe", {31'd0, if_e.rx_done_tick}, 32'h0);
    chk("reset_dout_odd", {24'd0, if_o.dout}, 32'h0);
    reset = 1'b0;
    drive_bit(1'b1, 100);

    // Clean even-parity frame.
    s0 = stb_cnt[0];
    send(8'hA5, 1'b0, 1'b1);
    chk("a5_strobes", stb_cnt[0] - s0, 32'd1);
    chk("a5_dout", {24'd0, if_e.dout}, 32'hA5);
    chk("a5_flags", {30'd0, if_e.parity_err, if_e.frame_err}, 32'h0);
    chk("a5_odd_perr", {31'd0, if_o.parity_err}, 32'd1);

    // Wrong then right parity for 0x07.
    send(8'h07, 1'b0, 1'b1);
    chk("07_bad_dout", {24'd0, if_e.dout}, 32'h07);
    chk("07_bad_perr", {31'd0, if_e.parity_err}, 32'd1);
    chk("07_bad_ferr", {31'd0, if_e.frame_err}, 32'd0);
    send(8'h07, 1'b1, 1'b1);
    chk("07_good_perr", {31'd0, if_e.parity_err}, 32'd0);

    // Stop bit low.
    send(8'h3C, 1'b0, 1'b0);
    chk("3c_dout", {24'd0, if_e.dout}, 32'h3C);
    chk("3c_ferr", {31'd0, if_e.frame_err}, 32'd1);
    chk("3c_perr", {31'd0, if_e.parity_err}, 32'd0);
    drive_bit(1'b1, 200);

    // 16-clk glitch in idle.
    s0 = stb_cnt[0];
    s1 = stb_cnt[1];
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 200);
    chk("glitch_no_strobe", stb_cnt[0] - s0, 32'd0);
    chk("glitch_no_strobe_odd", stb_cnt[1] - s1, 32'd0);
    chk("glitch_dout_held", {24'd0, if_e.dout}, 32'h3C);
    chk("glitch_ferr_held", {31'd0, if_e.frame_err}, 32'd1);
    send(8'h55, 1'b0, 1'b1);
    chk("55_dout", {24'd0, if_e.dout}, 32'h55);
    chk("55_ferr", {31'd0, if_e.frame_err}, 32'd0);
    drive_bit(1'b1, 100);

    // One-clk reset in the middle of data bit 3 of 0xFF; line then returns to idle.
    s0 = stb_cnt[0];
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, BIT_CLK);
    drive_bit(1'b1, 32);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      held[k] = '0;
      rd[k]   = frames.size();
    end
    @(negedge clk);
    reset = 1'b0;
    drive_bit(1'b1, 31 + 6 * BIT_CLK);
    chk("rst_no_strobe", stb_cnt[0] - s0, 32'd0);
    chk("rst_dout", {24'd0, if_e.dout}, 32'h0);
    chk("rst_flags_odd", {30'd0, if_o.parity_err, if_o.frame_err}, 32'h0);
    s0 = stb_cnt[0];
    send(8'h81, 1'b0, 1'b1);
    chk("81_strobes", stb_cnt[0] - s0, 32'd1);
    chk("81_dout", {24'd0, if_e.dout}, 32'h81);
    drive_bit(1'b1, 100);

    // Back-to-back frames without idle gap.
    s0 = stb_cnt[0];
    send(8'h00, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    send(8'h5A, 1'b0, 1'b1);
    chk("b2b_strobes", stb_cnt[0] - s0, 32'd3);
    chk("b2b_dout", {24'd0, if_e.dout}, 32'h5A);
    chk("b2b_perr", {31'd0, if_e.parity_err}, 32'd0);
    drive_bit(1'b1, 100);

    // Odd-parity receiver on 0xA5 with parity bit 1.
    send(8'hA5, 1'b1, 1'b1);
    chk("odd_a5_dout", {24'd0, if_o.dout}, 32'hA5);
    chk("odd_a5_perr", {31'd0, if_o.parity_err}, 32'd0);
    chk("odd_a5_even_perr", {31'd0, if_e.parity_err}, 32'd1);
    drive_bit(1'b1, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
